// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared pipeline constants: load funct3 codes and MEM/WB state encoding
package mem_wb_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_WAIT_MEM = 1'b1;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// rtl/mem_wb_stage_load_align.sv - combinational load formatter and misalignment/illegal-type detector
module load_align
  import mem_wb_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data,
  output logic        fault
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{addr, 3'b000} +: 8];
  assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data  = '0;
    fault = 1'b0;
    case (funct3)
      F3_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU: data = {24'b0, byte_sel};
      F3_LH: begin
        data  = {{16{half_sel[15]}}, half_sel};
        fault = addr[0];
      end
      F3_LHU: begin
        data  = {16'b0, half_sel};
        fault = addr[0];
      end
      F3_LW: begin
        data  = rdata;
        fault = (addr != 2'b00);
      end
      default: fault = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - memory/writeback stage: ALU passthrough and variable-latency loads to the register file
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [4:0]      ex_rd,
  input  logic [XLEN-1:0] ex_result,
  input  logic            ex_is_load,
  input  logic [2:0]      ex_funct3,
  output logic            dmem_req,
  output logic [XLEN-1:0] dmem_addr,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [4:0]      a_rd,
  output logic [XLEN-1:0] d_rd,
  output logic            we_rd,
  output logic            load_fault
);

  logic [0:0]  state;
  logic [4:0]  rd_q;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;
  logic [1:0]  align_addr;
  logic [2:0]  align_funct3;
  logic [31:0] align_data;
  logic        align_fault;
  logic        xfer;

  assign ex_ready = (state == ST_IDLE) && !reset;
  assign xfer     = ex_valid && ex_ready;

  // One formatter serves both uses: fault screening of the incoming load in IDLE,
  // and formatting of the returned word from the captured offset/type in WAIT_MEM.
  assign align_addr   = (state == ST_WAIT_MEM) ? offset_q : ex_result[1:0];
  assign align_funct3 = (state == ST_WAIT_MEM) ? funct3_q : ex_funct3;

  load_align u_load_align (
    .rdata  (dmem_rdata),
    .addr   (align_addr),
    .funct3 (align_funct3),
    .data   (align_data),
    .fault  (align_fault)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      dmem_req   <= 1'b0;
      dmem_addr  <= '0;
      we_rd      <= 1'b0;
      load_fault <= 1'b0;
      a_rd       <= '0;
      d_rd       <= '0;
      rd_q       <= '0;
      funct3_q   <= '0;
      offset_q   <= '0;
    end else begin
      we_rd      <= 1'b0;
      load_fault <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (xfer) begin
            if (!ex_is_load) begin
              we_rd <= 1'b1;
              a_rd  <= ex_rd;
              d_rd  <= ex_result;
            end else if (align_fault) begin
              load_fault <= 1'b1;
            end else begin
              state     <= ST_WAIT_MEM;
              dmem_req  <= 1'b1;
              dmem_addr <= {ex_result[XLEN-1:2], 2'b00};
              rd_q      <= ex_rd;
              funct3_q  <= ex_funct3;
              offset_q  <= ex_result[1:0];
            end
          end
        end
        default: begin
          if (dmem_ack) begin
            state    <= ST_IDLE;
            dmem_req <= 1'b0;
            we_rd    <= 1'b1;
            a_rd     <= rd_q;
            d_rd     <= align_data;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is supported.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have ports ex_valid in 1 and ex_ready out 1: execute-stage handshake; a transfer occurs when both are 1 at a rising edge.
REQ-005 SHALL have ports ex_rd in 5, ex_result in 32, ex_is_load in 1, ex_funct3 in 3: destination, ALU result or load address, load flag, and load type.
REQ-006 SHALL have ports dmem_req out 1, dmem_addr out 32, dmem_ack in 1, dmem_rdata in 32: variable-latency data-memory read.
REQ-007 SHALL have ports a_rd out 5, d_rd out 32, we_rd out 1: register-file write port.
REQ-008 SHALL have port load_fault out 1: one-cycle pulse for a misaligned or illegal load.

Function
REQ-009 SHALL implement states IDLE and WAIT_MEM, with ex_ready=1 in IDLE and ex_ready=0 in WAIT_MEM.
REQ-010 Non-load accepted at edge N SHALL produce we_rd=1, a_rd=ex_rd, d_rd=ex_result for exactly the cycle after N; state stays IDLE.
REQ-011 Aligned legal load accepted at edge N SHALL enter WAIT_MEM, with dmem_req=1 and dmem_addr={addr[31:2],2'b00} from the cycle after N.
REQ-012 dmem_req and dmem_addr SHALL hold stable until an edge where dmem_ack=1; ack may arrive in the first request cycle.
REQ-013 On the ack edge M, the block SHALL register formatted load data, return to IDLE, and drive we_rd=1 with a_rd=captured rd for exactly the cycle after M.
REQ-014 Load formatting: funct3 000 SHALL give LB, the byte selected by addr[1:0], sign-extended.
REQ-015 Load formatting: 001 SHALL give LH, the halfword selected by addr[1], sign-extended.
REQ-016 Load formatting: 010 SHALL give LW, the full word.
REQ-017 Load formatting: 100 SHALL give LBU and 101 SHALL give LHU, each zero-extended.
REQ-018 Load with funct3 in {011,110,111}, LH/LHU with addr[0]=1, or LW with addr[1:0]!=0 SHALL NOT request memory or write back.
REQ-019 For a faulting load, load_fault SHALL be 1 for exactly the cycle after acceptance, and the state SHALL stay IDLE.
REQ-020 A transfer SHALL be accepted in the cycle after a WAIT_MEM exit (back-to-back loads allowed).
REQ-021 Peak throughput SHALL be one transfer per cycle for non-loads.
REQ-022 ex_rd=0 SHALL still assert we_rd; the register file discards x0 writes.
REQ-023 dmem_ack SHALL be ignored in IDLE.
REQ-024 dmem_rdata SHALL be sampled only on the ack edge.
REQ-025 we_rd, load_fault and dmem_req SHALL be mutually exclusive in any cycle.
REQ-026 All outputs except ex_ready SHALL be driven from registers.

Reset
REQ-027 Reset SHALL force state IDLE and dmem_req=0, we_rd=0, load_fault=0, a_rd=0, d_rd=0, dmem_addr=0 in the cycle after the reset edge.
REQ-028 ex_ready SHALL be 0 while reset=1 and 1 in the first cycle after reset deasserts.
REQ-029 Reset during WAIT_MEM SHALL abandon the request without writeback; a subsequent late ack is ignored per REQ-023.
REQ-030 Reset SHALL take priority over any simultaneous transfer or ack.

Structure
REQ-031 The shared pipeline package SHALL hold the funct3 load-type constants and the state encoding.
REQ-032 Formatting SHALL live in one combinational sub-module, load_align (inputs rdata, addr[1:0], funct3; outputs data and fault).

Verification
REQ-033 ALU op rd=5, result=0x12345678 accepted at edge N -> cycle N+1: we_rd=1, a_rd=5, d_rd=0x12345678.
REQ-034 LB rd=3, addr=0x1003, ack 3 cycles later with rdata=0x80FF0011 -> dmem_addr=0x1000 held 3 cycles, then d_rd=0xFFFFFF80, ex_ready low throughout wait.
REQ-035 LHU addr=0x2002, rdata=0xBEEF1234, ack in first request cycle -> d_rd=0x0000BEEF one cycle after ack.
REQ-036 LW addr=0x3001 -> load_fault pulse one cycle, dmem_req never 1, we_rd never 1, next op accepted immediately.
REQ-037 Reset asserted in second WAIT_MEM cycle, ack arrives 2 cycles later -> dmem_req=0 after reset edge, no we_rd pulse.
REQ-038 LW rd=7 acked, followed by ALU op rd=7 in next ready cycle -> two consecutive-order writes, second value final.
